mmio_port_ctrl: RTL and testbench

MMIO_PORT_CTRL -- requirements
Module: mmio_port_ctrl

---
 rtl/mmio_port_ctrl.sv | 127 ++++++++++++
 tb/tb_mmio_port_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_port_ctrl.sv
// mmio_port_ctrl: memory-mapped pointer/data channels feeding a write queue toward a peripheral
module mmio_port_ctrl #(
    parameter int          NUM_CH     = 2,
    parameter int          PTR_W      = 13,
    parameter logic [15:0] BASE_ADDR  = 16'hFFF0,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             busWriteEnable,
    input  logic [15:0]      busWriteAddr,
    input  logic [15:0]      busWriteData,
    input  logic [15:0]      busReadAddr,
    output logic [15:0]      busReadData,
    output logic             busReadHit,
    output logic             periphValid,
    input  logic             periphReady,
    output logic [2:0]       periphCh,
    output logic [PTR_W-1:0] periphAddr,
    output logic [7:0]       periphData
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = 3 + PTR_W + 8;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    logic [PTR_W-1:0] ptr [NUM_CH];
    logic             autoInc [NUM_CH];
    logic [EW-1:0]    mem [FIFO_DEPTH];
    logic [AW-1:0]    wrPtr, rdPtr;
    logic [AW:0]      count;
    logic             overflow;
    logic [15:0]      wrOff, rdOff, rdWord;
    logic [PTR_W-1:0] curPtr;
    logic [4:0]       cntSat;
    logic [EW-1:0]    head;
    logic             wrCh, isLoad, isData, statusWr, full, empty, pop, pushOk, pushDrop, rdHit;

    assign wrOff    = busWriteAddr - BASE_ADDR;
    assign rdOff    = busReadAddr - BASE_ADDR;
    assign wrCh     = busWriteEnable && wrOff < 16'(NUM_CH);
    assign isLoad   = wrCh && busWriteData[15];
    assign isData   = wrCh && !busWriteData[15];
    assign statusWr = busWriteEnable && wrOff == 16'(NUM_CH);
    assign full     = count == FULL_CNT;
    assign empty    = count == '0;
    assign pop      = !empty && periphReady;
    assign pushOk   = isData && (!full || pop);
    assign pushDrop = isData && full && !pop;
    assign rdHit    = rdOff <= 16'(NUM_CH);
    assign cntSat   = (32'(count) > 32'd31) ? 5'd31 : 5'(count);

    assign head        = mem[rdPtr];
    assign periphValid = !empty;
    assign periphCh    = head[EW-1 -: 3];
    assign periphAddr  = head[8 +: PTR_W];
    assign periphData  = head[7:0];

    // Pointer of the channel addressed by the current write, captured into the queued entry
    always_comb begin
        curPtr = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (wrOff == 16'(i)) curPtr = ptr[i];
    end

    // Per-channel pointer and auto-increment mode; dropped data writes leave the pointer alone
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < NUM_CH; i++) begin
                ptr[i]     <= '0;
                autoInc[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (isLoad && wrOff == 16'(i)) begin
                    ptr[i]     <= PTR_W'(busWriteData[13:0]);
                    autoInc[i] <= busWriteData[14];
                end else if (pushOk && wrOff == 16'(i) && autoInc[i]) begin
                    ptr[i] <= ptr[i] + 1'b1;
                end
            end
        end
    end

    // Queue storage needs no reset: an empty queue never exposes its contents as valid
    always_ff @(posedge clk) begin
        if (pushOk) mem[wrPtr] <= {wrOff[2:0], curPtr, busWriteData[7:0]};
    end

    // Queue pointers and occupancy; a push into a full queue is legal when the head leaves together
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (pushOk) wrPtr <= wrPtr + 1'b1;
            if (pop) rdPtr <= rdPtr + 1'b1;
            count <= (pushOk && !pop) ? count + 1'b1 : (pop && !pushOk) ? count - 1'b1 : count;
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear wins
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) overflow <= 1'b0;
        else if (pushDrop) overflow <= 1'b1;
        else if (statusWr && busWriteData[0]) overflow <= 1'b0;
    end

    // Read mux: channel words then the status word; anything else reads as zero
    always_comb begin
        rdWord = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (rdOff == 16'(i)) rdWord = {autoInc[i], 15'(ptr[i])};
        if (rdOff == 16'(NUM_CH)) rdWord = {overflow, full, empty, 8'b0, cntSat};
    end

    // Registered read response, one cycle after the address is presented
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            busReadData <= '0;
            busReadHit  <= 1'b0;
        end else begin
            busReadData <= rdWord;
            busReadHit  <= rdHit;
        end
    end
endmodule

// File: tb/tb_mmio_port_ctrl.sv
// tb_mmio_port_ctrl: directed and randomized checks of mmio_port_ctrl against a queue-based model
module tb_mmio_port_ctrl;
    localparam int          NUM_CH = 2;
    localparam int          PTR_W  = 13;
    localparam int          DEPTH  = 4;
    localparam logic [15:0] BASE   = 16'hFFF0;

    logic             clk = 1'b0;
    logic             rstN = 1'b0;
    logic             busWriteEnable = 1'b0;
    logic [15:0]      busWriteAddr = '0;
    logic [15:0]      busWriteData = '0;
    logic [15:0]      busReadAddr = '0;
    logic [15:0]      busReadData;
    logic             busReadHit;
    logic             periphValid;
    logic             periphReady = 1'b0;
    logic [2:0]       periphCh;
    logic [PTR_W-1:0] periphAddr;
    logic [7:0]       periphData;

    mmio_port_ctrl #(.NUM_CH(NUM_CH), .PTR_W(PTR_W), .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rstN(rstN), .busWriteEnable(busWriteEnable), .busWriteAddr(busWriteAddr),
        .busWriteData(busWriteData), .busReadAddr(busReadAddr), .busReadData(busReadData),
        .busReadHit(busReadHit), .periphValid(periphValid), .periphReady(periphReady),
        .periphCh(periphCh), .periphAddr(periphAddr), .periphData(periphData)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ch;
        int addr;
        int data;
    } entry_t;

    entry_t      q[$];
    int          ptrM[NUM_CH];
    bit          aiM[NUM_CH];
    bit          ovfM;
    logic [15:0] expRd;
    bit          expHit;
    int          nTests = 0;
    int          nFail = 0;

    function automatic void model_reset();
        q.delete();
        for (int i = 0; i < NUM_CH; i++) begin
            ptrM[i] = 0;
            aiM[i] = 0;
        end
        ovfM = 0;
        expRd = '0;
        expHit = 0;
    endfunction

    function automatic logic [15:0] read_model(input logic [15:0] a, output bit hit);
        logic [15:0] d;
        int off, n;
        d = a - BASE;
        off = int'(d);
        hit = off <= NUM_CH;
        n = q.size() > 31 ? 31 : q.size();
        if (off < NUM_CH) return {aiM[off], 15'(ptrM[off])};
        if (off == NUM_CH) return {ovfM, q.size() == DEPTH, q.size() == 0, 8'b0, 5'(n)};
        return '0;
    endfunction

    // Advance the model by one clock using the inputs currently driven, then cross the edge
    task automatic step();
        logic [15:0] d;
        int off;
        bit popM, fullM;
        expRd = read_model(busReadAddr, expHit);
        popM = q.size() != 0 && periphReady;
        fullM = q.size() == DEPTH;
        if (popM) void'(q.pop_front());
        if (busWriteEnable) begin
            d = busWriteAddr - BASE;
            off = int'(d);
            if (off < NUM_CH) begin
                if (busWriteData[15]) begin
                    ptrM[off] = int'(busWriteData) % (1 << PTR_W);
                    aiM[off] = busWriteData[14];
                end else if (!fullM || popM) begin
                    q.push_back('{off, ptrM[off], int'(busWriteData[7:0])});
                    if (aiM[off]) ptrM[off] = (ptrM[off] + 1) % (1 << PTR_W);
                end else begin
                    ovfM = 1;
                end
            end else if (off == NUM_CH && busWriteData[0]) begin
                ovfM = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int ch, input logic [15:0] data);
        busWriteEnable = 1'b1;
        busWriteAddr = BASE + 16'(ch);
        busWriteData = data;
        step();
        busWriteEnable = 1'b0;
    endtask

    task automatic rd(input int ch);
        busReadAddr = BASE + 16'(ch);
        step();
    endtask

    task automatic test_reset();
        model_reset();
        #3;
        nTests++;
        if (periphValid !== 1'b0 || busReadHit !== 1'b0 || busReadData !== 16'h0) begin
            nFail++;
            $display("FAIL reset_outputs: valid=%b hit=%b data=%h required 0/0/0000", periphValid, busReadHit, busReadData);
        end
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1;
        rd(NUM_CH);
        nTests++;
        if (busReadData !== 16'h2000 || busReadHit !== 1'b1) begin
            nFail++;
            $display("FAIL reset_status: got %h hit=%b required 2000 hit=1", busReadData, busReadHit);
        end
    endtask

    task automatic test_autoinc();
        periphReady = 1'b1;
        wr(0, 16'hC123);
        wr(0, 16'h00AA);
        nTests++;
        if (periphValid !== 1'b1 || periphCh !== 3'd0 || periphAddr !== 13'h0123 || periphData !== 8'hAA) begin
            nFail++;
            $display("FAIL autoinc_first: v=%b ch=%0d addr=%h data=%h required 1/0/0123/aa", periphValid, periphCh, periphAddr, periphData);
        end
        wr(0, 16'h00BB);
        nTests++;
        if (periphValid !== 1'b1 || periphCh !== 3'd0 || periphAddr !== 13'h0124 || periphData !== 8'hBB) begin
            nFail++;
            $display("FAIL autoinc_second: v=%b ch=%0d addr=%h data=%h required 1/0/0124/bb", periphValid, periphCh, periphAddr, periphData);
        end
        rd(0);
        nTests++;
        if (busReadData !== 16'h8125 || busReadHit !== 1'b1 || expRd !== 16'h8125) begin
            nFail++;
            $display("FAIL autoinc_read: got %h hit=%b required 8125 hit=1", busReadData, busReadHit);
        end
        nTests++;
        if (periphValid !== 1'b0) begin
            nFail++;
            $display("FAIL autoinc_drain: valid=%b required 0", periphValid);
        end
    endtask

    task automatic test_wrap();
        periphReady = 1'b0;
        wr(1, 16'hDFFF);
        wr(1, 16'h0055);
        nTests++;
        if (periphValid !== 1'b1 || periphCh !== 3'd1 || periphAddr !== 13'h1FFF || periphData !== 8'h55) begin
            nFail++;
            $display("FAIL wrap_entry: v=%b ch=%0d addr=%h data=%h required 1/1/1fff/55", periphValid, periphCh, periphAddr, periphData);
        end
        rd(1);
        nTests++;
        if (busReadData !== 16'h8000 || busReadData !== expRd) begin
            nFail++;
            $display("FAIL wrap_ptr: got %h required 8000", busReadData);
        end
        periphReady = 1'b1;
        step();
        periphReady = 1'b0;
    endtask

    task automatic test_overflow();
        periphReady = 1'b0;
        for (int i = 0; i < 5; i++) wr(0, 16'($urandom_range(0, 255)));
        rd(NUM_CH);
        nTests++;
        if (busReadData !== 16'hC004 || busReadData !== expRd) begin
            nFail++;
            $display("FAIL overflow_status: got %h required c004", busReadData);
        end
        nTests++;
        if (periphAddr !== 13'h0125 || periphData !== 8'(q[0].data)) begin
            nFail++;
            $display("FAIL overflow_head: addr=%h data=%h required 0125/%h", periphAddr, periphData, 8'(q[0].data));
        end
        wr(NUM_CH, 16'h0001);
        rd(NUM_CH);
        nTests++;
        if (busReadData !== 16'h4004) begin
            nFail++;
            $display("FAIL overflow_clear: got %h required 4004", busReadData);
        end
    endtask

    task automatic test_push_pop_full();
        periphReady = 1'b1;
        busReadAddr = BASE + 16'(NUM_CH);
        wr(0, 16'h0077);
        periphReady = 1'b0;
        rd(NUM_CH);
        nTests++;
        if (busReadData !== 16'h4004 || busReadData !== expRd) begin
            nFail++;
            $display("FAIL pushpop_status: got %h required 4004", busReadData);
        end
        nTests++;
        if (periphAddr !== 13'h0126 || periphData !== 8'(q[0].data) || q[$].data !== 32'h77 || q[$].addr !== 32'h129) begin
            nFail++;
            $display("FAIL pushpop_head: addr=%h data=%h required 0126/%h", periphAddr, periphData, 8'(q[0].data));
        end
        periphReady = 1'b1;
        for (int i = 0; i < DEPTH; i++) step();
        periphReady = 1'b0;
        nTests++;
        if (periphValid !== 1'b0) begin
            nFail++;
            $display("FAIL pushpop_drain: valid=%b required 0", periphValid);
        end
    endtask

    task automatic test_async_reset();
        periphReady = 1'b0;
        for (int i = 0; i < 3; i++) wr(1, 16'h0010 + 16'(i));
        #3;
        rstN = 1'b0;
        #1;
        model_reset();
        nTests++;
        if (periphValid !== 1'b0 || busReadHit !== 1'b0 || busReadData !== 16'h0) begin
            nFail++;
            $display("FAIL async_reset: valid=%b hit=%b data=%h required 0/0/0000", periphValid, busReadHit, busReadData);
        end
        #2;
        rstN = 1'b1;
        rd(NUM_CH);
        nTests++;
        if (busReadData !== 16'h2000 || periphValid !== 1'b0) begin
            nFail++;
            $display("FAIL async_reset_status: got %h valid=%b required 2000 valid=0", busReadData, periphValid);
        end
    endtask

    task automatic test_no_autoinc();
        periphReady = 1'b0;
        wr(1, 16'h8100);
        for (int i = 0; i < 3; i++) wr(1, 16'h0030 + 16'(i));
        wr(5, 16'h1234);
        rd(5);
        nTests++;
        if (busReadHit !== 1'b0 || busReadData !== 16'h0) begin
            nFail++;
            $display("FAIL unmapped_read: hit=%b data=%h required 0/0000", busReadHit, busReadData);
        end
        rd(1);
        nTests++;
        if (busReadData !== 16'h0100) begin
            nFail++;
            $display("FAIL noinc_ptr: got %h required 0100", busReadData);
        end
        periphReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            nTests++;
            if (periphValid !== 1'b1 || periphCh !== 3'd1 || periphAddr !== 13'h0100 || periphData !== 8'h30 + 8'(i)) begin
                nFail++;
                $display("FAIL noinc_entry%0d: v=%b ch=%0d addr=%h data=%h required 1/1/0100/%h", i, periphValid, periphCh, periphAddr, periphData, 8'h30 + 8'(i));
            end
            step();
        end
        periphReady = 1'b0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            busWriteEnable = 1'($urandom_range(0, 1));
            busWriteAddr = ($urandom_range(0, 9) == 0) ? 16'($urandom) : BASE + 16'($urandom_range(0, 5));
            busWriteData = 16'($urandom);
            busWriteData[15] = $urandom_range(0, 4) == 0;
            busReadAddr = BASE - 16'd1 + 16'($urandom_range(0, 5));
            periphReady = $urandom_range(0, 2) == 0;
            step();
            nTests++;
            if (periphValid !== (q.size() != 0) || busReadData !== expRd || busReadHit !== expHit) begin
                nFail++;
                $display("FAIL random_%0d: valid=%b rd=%h hit=%b required %b/%h/%b", n, periphValid, busReadData, busReadHit, q.size() != 0, expRd, expHit);
            end
            if (q.size() != 0) begin
                nTests++;
                if (periphCh !== 3'(q[0].ch) || periphAddr !== PTR_W'(q[0].addr) || periphData !== 8'(q[0].data)) begin
                    nFail++;
                    $display("FAIL random_head_%0d: ch=%0d addr=%h data=%h required %0d/%h/%h", n, periphCh, periphAddr, periphData, q[0].ch, PTR_W'(q[0].addr), 8'(q[0].data));
                end
            end
        end
        busWriteEnable = 1'b0;
        periphReady = 1'b0;
    endtask

    initial begin
        test_reset();
        test_autoinc();
        test_wrap();
        test_overflow();
        test_push_pop_full();
        test_async_reset();
        test_no_autoinc();
        test_random();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
